echo_initiator: RTL and testbench
=================================

ECHO_INITIATOR -- requirements
Module: echo_initiator

Interface
REQ-001 Parameter CLK_FREQ_HZ, 50_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, 115200, UART bit rate; CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE (integer division).
REQ-003 Parameter FIFO_DEPTH, 8, sample buffer depth in bytes; power of two, at least 2.
REQ-004 Parameter TIMEOUT_FRAMES, 4, echo timeout in 10-bit UART frame times.
REQ-005 i_clk  in  1  single system clock; all logic on its rising edge.
REQ-006 i_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 i_smp_valid  in  1  upstream sample offered.
REQ-008 i_smp_data  in  8  upstream sample byte.
REQ-009 o_smp_ready  out  1  buffer can accept a sample.
REQ-010 o_tx_dv  out  1  one-cycle launch strobe to the byte-level UART transmitter.
REQ-011 o_tx_byte  out  8  byte to transmit; stable while o_tx_dv is high.
REQ-012 i_tx_active  in  1  transmitter busy.
REQ-013 i_rx_dv  in  1  one-cycle strobe from the byte-level UART receiver.
REQ-014 i_rx_byte  in  8  received (processed) byte.
REQ-015 o_res_valid  out  1  one-cycle strobe: processed byte returned.
REQ-016 o_res_data  out  8  returned byte; held until the next o_res_valid.
REQ-017 o_timeout  out  1  one-cycle strobe: echo not received in time.
REQ-018 o_busy  out  1  high whenever the FSM is not in S_IDLE.
REQ-019 o_err_count  out  16  saturating count of timeouts plus stray receive bytes.

Function
REQ-020 Sample handshake: a byte is written on each cycle where i_smp_valid && o_smp_ready; o_smp_ready = !full, independent of same-cycle pop.
REQ-021 The FIFO is first-in first-out; a write to a full FIFO is impossible, and a read from an empty FIFO never occurs.
REQ-022 FSM states: S_IDLE, S_LAUNCH, S_WAIT_ECHO.
REQ-023 S_IDLE: if the FIFO is non-empty and !i_tx_active, pop the head into o_tx_byte and go to S_LAUNCH; otherwise stay.
REQ-024 S_LAUNCH: o_tx_dv is high for exactly this one cycle; clear the timeout counter; go to S_WAIT_ECHO.
REQ-025 S_WAIT_ECHO: the timeout counter increments each cycle; on i_rx_dv, capture i_rx_byte into o_res_data, pulse o_res_valid the next cycle, and go to S_IDLE.
REQ-026 Timeout limit = CLKS_PER_BIT*10*TIMEOUT_FRAMES cycles after S_LAUNCH; on reaching it without i_rx_dv, pulse o_timeout, increment o_err_count, and go to S_IDLE.
REQ-027 If i_rx_dv and timeout expiry coincide, the received byte wins and no timeout is flagged.
REQ-028 i_rx_dv outside S_WAIT_ECHO is stray: it is discarded, o_res_valid is not pulsed, and o_err_count increments.
REQ-029 o_err_count saturates at 16'hFFFF and never wraps.
REQ-030 Latency: a sample written at edge N into an empty FIFO, with the FSM idle and i_tx_active low, yields o_tx_dv high in cycle N+2.
REQ-031 Only one byte is outstanding at a time; the next launch requires a return to S_IDLE.

Reset
REQ-032 While i_rst_n is low: the FSM is in S_IDLE, the FIFO is empty, and o_tx_dv, o_res_valid, and o_timeout are 0.
REQ-033 While i_rst_n is low: o_tx_byte and o_res_data are 8'h00, o_err_count is 0, o_busy is 0, and o_smp_ready is 0.
REQ-034 o_smp_ready rises one cycle after i_rst_n deasserts.
REQ-035 Reset asserted mid-operation aborts any outstanding echo without a timeout pulse.

Structure
REQ-036 Package echo_pkg holds the state_t enum (2-bit) and the localparams for frame bits (10) and byte width (8).
REQ-037 One sub-module, sync_fifo (parameterised by width and depth), provides the buffer, including full and empty flags; the FSM and counters live in echo_initiator.

Verification (CLK_FREQ_HZ=1_000_000, BAUD_RATE=100_000, TIMEOUT_FRAMES=4, timeout=400 cycles)
REQ-038 Push 8'hA5, with the model echoing i_rx_dv/8'h50 100 cycles after launch -> o_tx_dv for one cycle with 8'hA5, then o_res_valid with 8'h50, and o_err_count stays 0.
REQ-039 Push 8 bytes back-to-back with no echo -> o_smp_ready falls after the 8th write; 8 launches in order; 8 o_timeout pulses 400 cycles after each launch; o_err_count=8.
REQ-040 Hold i_tx_active high with FIFO non-empty -> no o_tx_dv until i_tx_active falls, then launch 2 cycles later.
REQ-041 i_rx_dv on exactly the 400th wait cycle -> o_res_valid is pulsed, with no o_timeout.
REQ-042 Stray i_rx_dv in S_IDLE -> no o_res_valid and o_err_count increments; a separate case forces the count to 16'hFFFF, then causes a timeout, and the count stays at 16'hFFFF.
REQ-043 Assert i_rst_n low during S_WAIT_ECHO with 3 bytes queued -> all outputs reach their reset values, the FIFO is empty, and no o_timeout is pulsed.

Source files
------------

// File: rtl/echo_pkg.sv
// Shared types and constants for the echo initiator: FSM encoding and UART framing.
package echo_pkg;

  localparam int FRAME_BITS = 10;
  localparam int BYTE_W     = 8;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LAUNCH    = 2'd1,
    S_WAIT_ECHO = 2'd2
  } state_t;

  // Echo deadline in clock cycles: whole UART frames at the integer bit period.
  function automatic int tmo_cycles(input int clk_hz, input int baud, input int frames);
    return (clk_hz / baud) * FRAME_BITS * frames;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; read data is the combinational head entry.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW:0]   PTR_ONE = (AW+1)'(1);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (i_wr_en && !o_full)  wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (i_rd_en && !o_empty) rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_wr_en && !o_full) mem_q[wr_ptr_q[AW-1:0]] <= i_wr_data;
  end

  // Same index with differing wrap bits means the writer has lapped the reader.
  assign o_empty   = (wr_ptr_q == rd_ptr_q);
  assign o_full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign o_rd_data = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/echo_initiator.sv
// Buffers sample bytes, launches one at a time to a UART TX and waits for the processed echo.
// state       | meaning
// S_IDLE      | nothing outstanding; pop head when buffer non-empty and TX free
// S_LAUNCH    | one-cycle launch strobe; timeout counter cleared
// S_WAIT_ECHO | waiting for the echo byte or the frame-time deadline
module echo_initiator
  import echo_pkg::*;
#(
  parameter int CLK_FREQ_HZ    = 50_000_000,
  parameter int BAUD_RATE      = 115200,
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_FRAMES = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_smp_valid,
  input  logic [BYTE_W-1:0] i_smp_data,
  output logic              o_smp_ready,
  output logic              o_tx_dv,
  output logic [BYTE_W-1:0] o_tx_byte,
  input  logic              i_tx_active,
  input  logic              i_rx_dv,
  input  logic [BYTE_W-1:0] i_rx_byte,
  output logic              o_res_valid,
  output logic [BYTE_W-1:0] o_res_data,
  output logic              o_timeout,
  output logic              o_busy,
  output logic [15:0]       o_err_count
);

  localparam int               TMO_LIMIT = tmo_cycles(CLK_FREQ_HZ, BAUD_RATE, TIMEOUT_FRAMES);
  localparam int               TMO_W     = $clog2(TMO_LIMIT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TMO_LIMIT - 1);
  localparam logic [TMO_W-1:0] TMO_ONE   = TMO_W'(1);
  localparam logic [15:0]      ERR_MAX   = 16'hFFFF;

  state_t            state_q, state_d;
  logic [BYTE_W-1:0] tx_byte_q, tx_byte_d;
  logic [BYTE_W-1:0] res_data_q, res_data_d;
  logic              res_valid_q, res_valid_d;
  logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic [15:0]       err_q, err_d;
  logic              rdy_en_q, rdy_en_d;

  logic              fifo_wr, fifo_rd, fifo_full, fifo_empty;
  logic [BYTE_W-1:0] fifo_rd_data;
  logic              tmo_fire, err_inc;

  assign fifo_wr = i_smp_valid && o_smp_ready;

  sync_fifo #(
    .WIDTH (BYTE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_wr_en   (fifo_wr),
    .i_wr_data (i_smp_data),
    .i_rd_en   (fifo_rd),
    .o_rd_data (fifo_rd_data),
    .o_full    (fifo_full),
    .o_empty   (fifo_empty)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      tx_byte_q   <= '0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
      tmo_cnt_q   <= '0;
      err_q       <= '0;
      rdy_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      tx_byte_q   <= tx_byte_d;
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
      tmo_cnt_q   <= tmo_cnt_d;
      err_q       <= err_d;
      rdy_en_q    <= rdy_en_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    tx_byte_d   = tx_byte_q;
    res_data_d  = res_data_q;
    res_valid_d = 1'b0;
    tmo_cnt_d   = tmo_cnt_q;
    fifo_rd     = 1'b0;
    tmo_fire    = 1'b0;
    rdy_en_d    = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty && !i_tx_active) begin
          fifo_rd   = 1'b1;
          tx_byte_d = fifo_rd_data;
          state_d   = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        tmo_cnt_d = '0;
        state_d   = S_WAIT_ECHO;
      end
      S_WAIT_ECHO: begin
        // An echo landing on the deadline cycle takes priority over the timeout.
        if (i_rx_dv) begin
          res_data_d  = i_rx_byte;
          res_valid_d = 1'b1;
          state_d     = S_IDLE;
        end else if (tmo_cnt_q == TMO_LAST) begin
          tmo_fire = 1'b1;
          state_d  = S_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    err_inc = tmo_fire || (i_rx_dv && (state_q != S_WAIT_ECHO));
    err_d   = err_q;
    if (err_inc && (err_q != ERR_MAX)) err_d = err_q + 16'd1;
  end

  always_comb begin
    o_tx_dv     = (state_q == S_LAUNCH);
    o_busy      = (state_q != S_IDLE);
    o_timeout   = tmo_fire;
    o_smp_ready = rdy_en_q && !fifo_full;
    o_tx_byte   = tx_byte_q;
    o_res_valid = res_valid_q;
    o_res_data  = res_data_q;
    o_err_count = err_q;
  end

endmodule

// File: tb/tb_echo_initiator.sv
// Directed bench for echo_initiator with a cycle-indexed reference model and literal spot checks.
module tb_echo_initiator;

  localparam int TMO   = 400;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        smp_valid = 1'b0;
  logic [7:0]  smp_data = 8'h00;
  logic        tx_active = 1'b0;
  logic        rx_dv = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        o_smp_ready, o_tx_dv, o_res_valid, o_timeout, o_busy;
  logic [7:0]  o_tx_byte, o_res_data;
  logic [15:0] o_err_count;

  echo_initiator #(
    .CLK_FREQ_HZ    (1_000_000),
    .BAUD_RATE      (100_000),
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_FRAMES (4)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_smp_valid (smp_valid),
    .i_smp_data  (smp_data),
    .o_smp_ready (o_smp_ready),
    .o_tx_dv     (o_tx_dv),
    .o_tx_byte   (o_tx_byte),
    .i_tx_active (tx_active),
    .i_rx_dv     (rx_dv),
    .i_rx_byte   (rx_byte),
    .o_res_valid (o_res_valid),
    .o_res_data  (o_res_data),
    .o_timeout   (o_timeout),
    .o_busy      (o_busy),
    .o_err_count (o_err_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  // Events observed on the DUT outputs.
  int         n_launch = 0, n_tmo = 0, n_res = 0;
  int         launch_cyc = 0, tmo_gap = 0;
  logic [7:0] launch_byte = 8'h00, res_byte = 8'h00;
  logic [7:0] launched[$];

  // Reference model: buffered bytes, cycle of the outstanding launch (-1 when none).
  logic [7:0]  mq[$];
  int          m_launch_at = -1;
  bit          m_rv = 1'b0;
  bit          m_rdy_en = 1'b0;
  logic [7:0]  m_res_data = 8'h00, m_tx_byte = 8'h00;
  logic [15:0] m_err = 16'h0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expire(input string what);
    n_checks++;
    n_err++;
    $display("FAIL %s: wait bound expired, event not seen, required one (cycle %0d)", what, cyc);
  endtask

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always @(negedge clk) begin : compare
    int   c;
    bit   idle_now, waiting, e_tmo, e_rdy, rv_next;
    c = cyc;
    if (!rst_n) begin
      check("rst_tx_dv",     o_tx_dv, 0);
      check("rst_res_valid", o_res_valid, 0);
      check("rst_timeout",   o_timeout, 0);
      check("rst_tx_byte",   o_tx_byte, 8'h00);
      check("rst_res_data",  o_res_data, 8'h00);
      check("rst_err_count", o_err_count, 0);
      check("rst_busy",      o_busy, 0);
      check("rst_smp_ready", o_smp_ready, 0);
      mq.delete();
      m_launch_at = -1;
      m_rv        = 1'b0;
      m_rdy_en    = 1'b0;
      m_res_data  = 8'h00;
      m_tx_byte   = 8'h00;
      m_err       = 16'h0000;
    end else begin
      idle_now = (m_launch_at < 0);
      waiting  = !idle_now && (c > m_launch_at);
      e_tmo    = waiting && (c - m_launch_at == TMO) && !rx_dv;
      e_rdy    = m_rdy_en && (mq.size() < DEPTH);

      check("tx_dv",     o_tx_dv, (c == m_launch_at));
      check("busy",      o_busy, !idle_now);
      check("timeout",   o_timeout, e_tmo);
      check("smp_ready", o_smp_ready, e_rdy);
      check("res_valid", o_res_valid, m_rv);
      check("res_data",  o_res_data, m_res_data);
      check("tx_byte",   o_tx_byte, m_tx_byte);
      check("err_count", o_err_count, m_err);

      if (o_tx_dv) begin
        n_launch++;
        launch_cyc  = c;
        launch_byte = o_tx_byte;
        launched.push_back(o_tx_byte);
      end
      if (o_timeout) begin
        n_tmo++;
        tmo_gap = c - launch_cyc;
      end
      if (o_res_valid) begin
        n_res++;
        res_byte = o_res_data;
      end

      rv_next = 1'b0;
      if (waiting && rx_dv) begin
        m_res_data  = rx_byte;
        rv_next     = 1'b1;
        m_launch_at = -1;
      end else if (e_tmo) begin
        m_err       = sat_inc(m_err);
        m_launch_at = -1;
      end
      if (rx_dv && !waiting) m_err = sat_inc(m_err);
      if (idle_now && (mq.size() > 0) && !tx_active) begin
        m_tx_byte   = mq.pop_front();
        m_launch_at = c + 1;
      end
      if (smp_valid && e_rdy) mq.push_back(smp_data);
      m_rv     = rv_next;
      m_rdy_en = 1'b1;
    end
    cyc = cyc + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    smp_valid = 1'b1;
    smp_data  = b;
    tick();
    smp_valid = 1'b0;
  endtask

  task automatic drive_rx_at(input int t, input logic [7:0] b);
    while (cyc < t) tick();
    rx_dv   = 1'b1;
    rx_byte = b;
    tick();
    rx_dv   = 1'b0;
  endtask

  function automatic int ev_count(input int sel);
    case (sel)
      0:       return n_launch;
      1:       return n_tmo;
      default: return n_res;
    endcase
  endfunction

  task automatic wait_for(input int sel, input int target, input int budget, input string what);
    int k = 0;
    while (ev_count(sel) < target && k < budget) begin
      tick();
      k++;
    end
    if (ev_count(sel) < target) expire(what);
  endtask

  initial begin : stimulus
    int b_launch, b_tmo, b_res, wr_cyc, last_hi, k;

    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("ready_after_reset", o_smp_ready, 1);

    // Single byte echoed 100 cycles after launch.
    b_launch = n_launch; b_tmo = n_tmo; b_res = n_res;
    wr_cyc = cyc;
    push(8'hA5);
    wait_for(0, b_launch + 1, 10, "a5_launch");
    check("a5_latency", launch_cyc - wr_cyc, 2);
    check("a5_tx_byte", launch_byte, 8'hA5);
    drive_rx_at(launch_cyc + 100, 8'h50);
    wait_for(2, b_res + 1, 10, "a5_result");
    check("a5_res_byte", res_byte, 8'h50);
    check("a5_err", o_err_count, 16'd0);
    check("a5_no_timeout", n_tmo - b_tmo, 0);

    // Fill the buffer while TX is busy, then let all eight time out.
    b_launch = n_launch; b_tmo = n_tmo;
    launched.delete();
    tx_active = 1'b1;
    tick();
    smp_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      smp_data = 8'h10 + 8'(i);
      tick();
    end
    smp_valid = 1'b0;
    check("full_ready_low", o_smp_ready, 0);
    tx_active = 1'b0;
    wait_for(1, b_tmo + 8, 4000, "burst_timeouts");
    check("burst_launches", n_launch - b_launch, 8);
    check("burst_tmo_gap", tmo_gap, 400);
    check("burst_err", o_err_count, 16'd8);
    check("burst_order_size", launched.size(), 8);
    for (int i = 0; i < 8 && i < launched.size(); i++)
      check("burst_order", launched[i], 8'h10 + 8'(i));

    // Stray echo while idle.
    b_res = n_res;
    tick();
    rx_dv = 1'b1; rx_byte = 8'h77;
    tick();
    rx_dv = 1'b0;
    repeat (3) tick();
    check("stray_no_res", n_res - b_res, 0);
    check("stray_err", o_err_count, 16'd9);

    // TX busy holds off the launch; launch two edges after the last busy cycle.
    b_launch = n_launch; b_res = n_res;
    tx_active = 1'b1;
    push(8'h3C);
    repeat (20) tick();
    check("hold_no_launch", n_launch - b_launch, 0);
    last_hi = cyc;
    tick();
    tx_active = 1'b0;
    wait_for(0, b_launch + 1, 10, "hold_launch");
    check("hold_latency", launch_cyc - last_hi, 2);
    check("hold_tx_byte", launch_byte, 8'h3C);
    drive_rx_at(launch_cyc + 5, 8'hC3);
    wait_for(2, b_res + 1, 10, "hold_result");
    check("hold_res_byte", res_byte, 8'hC3);

    // Echo on the deadline cycle wins over the timeout.
    b_launch = n_launch; b_tmo = n_tmo; b_res = n_res;
    push(8'h5A);
    wait_for(0, b_launch + 1, 10, "edge_launch");
    drive_rx_at(launch_cyc + 400, 8'h96);
    wait_for(2, b_res + 1, 10, "edge_result");
    repeat (5) tick();
    check("edge_res_byte", res_byte, 8'h96);
    check("edge_no_timeout", n_tmo - b_tmo, 0);
    check("edge_err", o_err_count, 16'd9);

    // Reset while waiting for an echo with three bytes still queued.
    b_launch = n_launch;
    smp_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      smp_data = 8'hB0 + 8'(i);
      tick();
    end
    smp_valid = 1'b0;
    wait_for(0, b_launch + 1, 10, "rst_launch");
    repeat (50) tick();
    check("rst_pre_busy", o_busy, 1);
    rst_n = 1'b0;
    tick();
    tick();
    check("rst_mid_busy", o_busy, 0);
    check("rst_mid_ready", o_smp_ready, 0);
    check("rst_mid_err", o_err_count, 16'd0);
    rst_n = 1'b1;
    b_launch = n_launch; b_tmo = n_tmo;
    repeat (500) tick();
    check("rst_no_timeout", n_tmo - b_tmo, 0);
    check("rst_fifo_empty", n_launch - b_launch, 0);
    check("rst_ready_back", o_smp_ready, 1);

    // Drive the error count to saturation with strays, then add a timeout on top.
    rx_dv = 1'b1; rx_byte = 8'h00;
    k = 0;
    while (m_err != 16'hFFFF && k < 70000) begin
      tick();
      k++;
    end
    tick();
    rx_dv = 1'b0;
    tick();
    check("sat_err", o_err_count, 16'hFFFF);
    b_tmo = n_tmo;
    push(8'hE1);
    wait_for(1, b_tmo + 1, 500, "sat_timeout");
    tick();
    check("sat_err_after_tmo", o_err_count, 16'hFFFF);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
